// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: keeps a fetch PC and allows one outstanding
// instruction-memory read. Returned words go into a 2-entry {pc, instr}
// queue that feeds decode. A downstream redirect flushes the queue,
// retargets the fetch PC and discards any read still in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  // IDLE: nothing in flight; WAIT: one read in flight whose data is kept;
  // DROP: one read in flight whose data belongs to a squashed path.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic [1:0]  count;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic [31:0] tail_pc;
  logic [31:0] tail_instr;

  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  occ_after;
  logic [31:0] target_pc;

  // Redirect targets are forced to word alignment.
  assign target_pc = redirect_pc_i & 32'hFFFF_FFFC;

  // Queue events and request decision for the current cycle. A new read is
  // only issued if its response is guaranteed a free queue slot, so the
  // queue can never overflow.
  always_comb begin
    push      = (state == WAIT) && imem_rvalid_i && !redirect_i;
    pop       = (count != 2'd0) && instr_ready_i && !redirect_i;
    occ_after = {1'b0, count} + {2'b00, push} - {2'b00, pop};
    issue     = rst_i && !redirect_i
                && ((state == IDLE) || ((state == WAIT) && imem_rvalid_i))
                && (occ_after <= 3'd1);
  end

  assign imem_req_o    = issue;
  assign imem_addr_o   = issue ? fetch_pc : 32'h0000_0000;
  assign instr_valid_o = (count != 2'd0);
  assign instr_o       = head_instr;
  assign pc_o          = head_pc;

  // Read-tracking FSM: one outstanding read, squashed by redirect.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (issue) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid_i)   state <= issue ? WAIT : IDLE;
          else if (redirect_i) state <= DROP;
        end
        DROP: begin
          if (imem_rvalid_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Fetch PC advance/retarget and the address of the read in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc <= RESET_PC;
      req_pc   <= 32'h0000_0000;
    end else begin
      if (redirect_i)  fetch_pc <= target_pc;
      else if (issue)  fetch_pc <= fetch_pc + 32'd4;
      if (issue)       req_pc   <= fetch_pc;
    end
  end

  // Two-entry in-order queue; head entry drives the decode outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count      <= 2'd0;
      head_pc    <= 32'h0000_0000;
      head_instr <= 32'h0000_0000;
      tail_pc    <= 32'h0000_0000;
      tail_instr <= 32'h0000_0000;
    end else if (redirect_i) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_pc    <= req_pc;
            head_instr <= imem_rdata_i;
          end else begin
            tail_pc    <= req_pc;
            tail_instr <= imem_rdata_i;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_pc    <= tail_pc;
          head_instr <= tail_instr;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_pc    <= req_pc;
            head_instr <= imem_rdata_i;
          end else begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
            tail_pc    <= req_pc;
            tail_instr <= imem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural memory responder, directed
// scenarios and a randomized run, with a scoreboard of expected
// {pc, instr} deliveries checked by an independent monitor.
module tb_instr_fetch_unit;

  localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] HI_RESET_PC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ivalid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready;

  logic        h_req;
  logic [31:0] h_addr;
  logic        h_rvalid;
  logic [31:0] h_rdata;
  logic        h_ivalid;
  logic [31:0] h_instr;
  logic [31:0] h_pc;

  instr_fetch_unit #(.RESET_PC(MAIN_RESET_PC)) u_dut (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(req), .imem_addr_o(addr),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(ivalid), .instr_o(instr), .pc_o(pc),
    .instr_ready_i(ready)
  );

  instr_fetch_unit #(.RESET_PC(HI_RESET_PC)) u_dut_hi (
    .clk_i(clk), .rst_i(rst_n),
    .imem_req_o(h_req), .imem_addr_o(h_addr),
    .imem_rvalid_i(h_rvalid), .imem_rdata_i(h_rdata),
    .redirect_i(1'b0), .redirect_pc_i(32'h0000_0000),
    .instr_valid_o(h_ivalid), .instr_o(h_instr), .pc_o(h_pc),
    .instr_ready_i(1'b1)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] a; int c; } log_t;

  ent_t        exp_q[$];
  log_t        req_log[$];
  log_t        del_log[$];
  logic [31:0] hi_log[$];

  int n_vec = 0;
  int n_err = 0;
  int n_del = 0;
  int cyc   = 0;

  logic        stray;
  int          mem_lat;
  logic [31:0] ref_pc;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] ra(input int i);
    if (i < req_log.size()) return req_log[i].a;
    return 32'hxxxx_xxxx;
  endfunction
  function automatic int rcy(input int i);
    if (i < req_log.size()) return req_log[i].c;
    return -1;
  endfunction
  function automatic logic [31:0] dp(input int i);
    if (i < del_log.size()) return del_log[i].a;
    return 32'hxxxx_xxxx;
  endfunction
  function automatic int dcy(input int i);
    if (i < del_log.size()) return del_log[i].c;
    return -1;
  endfunction
  function automatic logic [31:0] ha(input int i);
    if (i < hi_log.size()) return hi_log[i];
    return 32'hxxxx_xxxx;
  endfunction
  function automatic bit has_req(input logic [31:0] a);
    foreach (req_log[i]) if (req_log[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: decode must see consecutive word addresses starting at
  // the last reset/redirect point, each carrying its memory word.
  function automatic void topup();
    ent_t e;
    while (exp_q.size() < 4) begin
      e.pc    = ref_pc;
      e.instr = memf(ref_pc);
      exp_q.push_back(e);
      ref_pc  = ref_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] start);
    exp_q.delete();
    ref_pc = start;
    topup();
  endfunction

  // Memory responder: one read at a time, fixed or random latency, plus an
  // injectable stray response; the second instance gets a 1-cycle memory.
  logic        pend, h_pend;
  logic [31:0] paddr, h_paddr;
  int          due;
  initial begin
    rvalid = 1'b0; rdata = 32'h0; h_rvalid = 1'b0; h_rdata = 32'h0;
    pend = 1'b0; h_pend = 1'b0; paddr = 32'h0; h_paddr = 32'h0; due = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      rvalid = 1'b0;
      if (stray) begin
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
      end else if (pend && cyc == due) begin
        rvalid = 1'b1;
        rdata  = memf(paddr);
        pend   = 1'b0;
      end
      h_rvalid = h_pend;
      h_rdata  = memf(h_paddr);
      h_pend   = 1'b0;
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; h_pend = 1'b0;
      end else begin
        if (req) begin
          pend  = 1'b1;
          paddr = addr;
          due   = cyc + ((mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat);
        end
        if (h_req) begin
          h_pend  = 1'b1;
          h_paddr = h_addr;
        end
      end
    end
  end

  // Monitor: scoreboard pops on every accepted instruction, plus request
  // address/protocol tracking and head stability while stalled.
  logic [31:0] exp_req = MAIN_RESET_PC;
  logic        outst = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_pc, hold_instr;
  always @(negedge clk) begin
    ent_t e;
    log_t l;
    if (!rst_n) begin
      exp_req = MAIN_RESET_PC;
      outst   = 1'b0;
      hold    = 1'b0;
    end else begin
      if (hold) begin
        chk1("hold_valid", ivalid, 1'b1);
        chk("hold_pc", pc, hold_pc);
        chk("hold_instr", instr, hold_instr);
      end
      hold       = ivalid && !ready && !redirect;
      hold_pc    = pc;
      hold_instr = instr;
      if (ivalid && ready && !redirect) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL deliver_unexpected: pc %h delivered with nothing expected", pc);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc", pc, e.pc);
          chk("deliver_instr", instr, e.instr);
        end
        l.a = pc; l.c = cyc;
        del_log.push_back(l);
        n_del++;
      end
      if (rvalid) outst = 1'b0;
      if (req) begin
        chk1("req_without_redirect", redirect, 1'b0);
        chk1("req_single_outstanding", outst, 1'b0);
        chk("req_addr", addr, exp_req);
        exp_req = exp_req + 32'd4;
        outst   = 1'b1;
        l.a = addr; l.c = cyc;
        req_log.push_back(l);
      end
      if (redirect) exp_req = redirect_pc & 32'hFFFF_FFFC;
      if (h_req) hi_log.push_back(h_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    topup();
  endtask

  int rel_cyc;
  task automatic do_reset(input int n, input bit with_stray);
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    redirect = 1'b0;
    restart(MAIN_RESET_PC);
    stray = with_stray;
    tick();
    stray = 1'b0;
    chk1("reset_req", req, 1'b0);
    chk1("reset_valid", ivalid, 1'b0);
    chk("reset_instr", instr, 32'h0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_addr", addr, 32'h0);
    repeat (n) tick();
    stray = with_stray;
    tick();
    rst_n = 1'b1;
    stray = 1'b0;
    req_log.delete(); del_log.delete(); hi_log.delete();
    rel_cyc = cyc;
  endtask

  initial begin
    int rc;
    int base;
    bit found;
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    stray = 1'b0; mem_lat = 1; ref_pc = MAIN_RESET_PC;
    topup();

    // Streaming from reset with 1-cycle memory; also the high reset PC wrap.
    ready = 1'b1; mem_lat = 1;
    do_reset(2, 1'b0);
    repeat (8) tick();
    for (int i = 0; i < 3; i++) begin
      chk("stream_req_addr", ra(i), 32'(i * 4));
      chk("stream_req_cycle", rcy(i), rel_cyc + i);
      chk("stream_del_pc", dp(i), 32'(i * 4));
      chk("stream_del_cycle", dcy(i), rel_cyc + 2 + i);
    end
    chk("hi_req0", ha(0), 32'hFFFF_FFF8);
    chk("hi_req1", ha(1), 32'hFFFF_FFFC);
    chk("hi_req2", ha(2), 32'h0000_0000);

    // Decode stalled: queue fills with two entries, fetch stops, then resumes.
    ready = 1'b0; mem_lat = 1;
    do_reset(2, 1'b0);
    repeat (10) tick();
    chk("stall_nreq", req_log.size(), 2);
    chk("stall_req0", ra(0), 32'h0);
    chk("stall_req1", ra(1), 32'h4);
    chk1("stall_valid", ivalid, 1'b1);
    chk("stall_head_pc", pc, 32'h0);
    ready = 1'b1;
    repeat (8) tick();
    chk("resume_req", ra(2), 32'h8);
    for (int i = 0; i < 4; i++) chk("resume_del_pc", dp(i), 32'(i * 4));

    // Redirect to 0x103 while the 3-cycle read of 0x8 is in flight.
    ready = 1'b1; mem_lat = 3;
    do_reset(2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (has_req(32'h8)) found = 1'b1;
    end
    chk1("drop_saw_req8", found, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    restart(32'h0000_0100);
    rc = cyc;
    req_log.delete(); del_log.delete();
    tick();
    redirect = 1'b0;
    repeat (15) tick();
    chk("drop_next_req", ra(0), 32'h100);
    chk("drop_next_req_cycle", rcy(0), rc + 3);
    chk("drop_first_del", dp(0), 32'h100);

    // Redirect coinciding with a response while decode is ready.
    ready = 1'b0; mem_lat = 2;
    do_reset(2, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (has_req(32'h4)) found = 1'b1;
    end
    chk1("same_cycle_saw_req4", found, 1'b1);
    tick();
    chk1("same_cycle_valid_before", ivalid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; ready = 1'b1;
    restart(32'h0000_0200);
    rc = cyc;
    req_log.delete(); del_log.delete();
    tick();
    redirect = 1'b0;
    chk1("same_cycle_flushed", ivalid, 1'b0);
    repeat (8) tick();
    chk("same_cycle_req", ra(0), 32'h200);
    chk("same_cycle_req_cycle", rcy(0), rc + 1);
    chk("same_cycle_first_del", dp(0), 32'h200);

    // Reset while a read is outstanding, stray responses around release.
    ready = 1'b1; mem_lat = 3;
    found = 1'b0;
    req_log.delete();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (req_log.size() != 0) found = 1'b1;
    end
    chk1("midread_saw_req", found, 1'b1);
    do_reset(1, 1'b1);
    repeat (12) tick();
    chk("midread_first_req", ra(0), MAIN_RESET_PC);
    chk("midread_first_del", dp(0), MAIN_RESET_PC);

    // Randomized traffic: latency, backpressure, redirects, occasional reset.
    mem_lat = 0;
    base = n_del;
    for (int i = 0; i < 3000; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 499) == 0) begin
        do_reset(1, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 99) < 4) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                                  : 32'($urandom);
        restart(redirect_pc & 32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
      end else begin
        tick();
      end
    end
    chk1("random_progress", (n_del - base) > 200, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time bound");
    $fatal(1, "watchdog");
  end

endmodule
